// File: rtl/seu_dpr_heal_sequencer_pkg.sv
// Shared types and helpers for the multi-region SEFI heal sequencer.
package seu_heal_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StVeto,
        StReq,
        StWait,
        StCool
    } heal_state_e;

    localparam int unsigned CLK_HZ = 600_000_000;

    function automatic int unsigned region_w(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Converts a DPR watchdog time in milliseconds to clock cycles.
    function automatic int unsigned dpr_timeout_from_ms(int unsigned ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/seu_dpr_heal_sequencer_if.sv
// Request/acknowledge link between the heal sequencer and the DPR/ICAP controller.
interface seu_dpr_heal_sequencer_if #(
    parameter int unsigned RW = 2
);
    logic          dpr_req;
    logic [RW-1:0] dpr_region;
    logic          dpr_ack;
    logic          dpr_done;
    logic          dpr_err;

    modport master (
        output dpr_req,
        output dpr_region,
        input  dpr_ack,
        input  dpr_done,
        input  dpr_err
    );

    modport slave (
        input  dpr_req,
        input  dpr_region,
        output dpr_ack,
        output dpr_done,
        output dpr_err
    );
endinterface

// File: rtl/seu_dpr_heal_sequencer_rr_arbiter.sv
// Round-robin arbiter: first set request at or after ptr, wrapping N-1 -> 0.
module seu_rr_arbiter
    import seu_heal_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned RW = region_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [RW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [RW-1:0] idx,
    output logic          valid
);

    // ptr is always < N, so a single subtraction is enough to wrap.
    function automatic logic [RW-1:0] wrap_idx(logic [RW-1:0] p, int unsigned off);
        int unsigned s;
        s = 32'(p) + off;
        if (s >= N) begin
            s = s - N;
        end
        return s[RW-1:0];
    endfunction

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int unsigned off = 0; off < N; off++) begin
            if (!valid && req[wrap_idx(ptr, off)]) begin
                valid                      = 1'b1;
                grant[wrap_idx(ptr, off)] = 1'b1;
                idx                        = wrap_idx(ptr, off);
            end
        end
    end

endmodule

// File: rtl/seu_dpr_heal_sequencer.sv
// Multi-region SEFI healer: vetoes the core, requests DPR of one region at a time,
// retries on error/timeout and reports regions that could not be healed.
module seu_dpr_heal_sequencer
    import seu_heal_pkg::*;
#(
    parameter int unsigned N_REGIONS   = 4,
    parameter int unsigned VETO_CYCLES = 16,
    parameter int unsigned DPR_TIMEOUT = dpr_timeout_from_ms(15),
    parameter int unsigned MAX_RETRY   = 2,
    parameter int unsigned COOL_CYCLES = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                     clk_600mhz,
    input  logic                     rst_n,
    input  logic [N_REGIONS-1:0]     sefi_flag,
    input  logic [N_REGIONS-1:0]     fail_clr,
    seu_dpr_heal_sequencer_if.master dpr,
    output logic                     veto_pulse,
    output logic                     busy,
    output logic [N_REGIONS-1:0]     region_failed,
    output logic [CNT_W-1:0]         heal_count
);

    localparam int unsigned RW      = region_w(N_REGIONS);
    localparam int unsigned RTW     = region_w(MAX_RETRY + 1);
    localparam int unsigned TMAX_VC = (VETO_CYCLES > COOL_CYCLES) ? VETO_CYCLES : COOL_CYCLES;
    localparam int unsigned TMAX    = (DPR_TIMEOUT > TMAX_VC) ? DPR_TIMEOUT : TMAX_VC;
    localparam int unsigned TW      = $clog2(TMAX + 1);

    heal_state_e          state_q, state_d;
    logic [N_REGIONS-1:0] sefi_q;
    logic [N_REGIONS-1:0] pend_q, pend_d, pend_clr;
    logic [N_REGIONS-1:0] failed_q, failed_d, fail_set;
    logic [RW-1:0]        region_q, region_d;
    logic [RW-1:0]        ptr_q, ptr_d;
    logic [RTW-1:0]       retry_q, retry_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [CNT_W-1:0]     heal_q, heal_d;

    logic [N_REGIONS-1:0] eligible;
    logic [N_REGIONS-1:0] grant;
    logic [RW-1:0]        grant_idx;
    logic                 grant_valid;
    logic                 wait_timeout;

    assign eligible     = pend_q & ~failed_q;
    assign wait_timeout = (timer_q == TW'(DPR_TIMEOUT - 1));

    seu_rr_arbiter #(
        .N  (N_REGIONS),
        .RW (RW)
    ) u_arb (
        .req   (eligible),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (grant_idx),
        .valid (grant_valid)
    );

    // A fresh edge on the region just granted survives the clear and heals it again.
    assign pend_d   = (pend_q & ~pend_clr) | (sefi_flag & ~sefi_q);
    assign failed_d = (failed_q & ~fail_clr) | fail_set;

    always_comb begin
        state_d  = state_q;
        region_d = region_q;
        ptr_d    = ptr_q;
        retry_d  = retry_q;
        timer_d  = timer_q;
        heal_d   = heal_q;
        pend_clr = '0;
        fail_set = '0;
        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    region_d = grant_idx;
                    pend_clr = grant;
                    ptr_d    = (grant_idx == RW'(N_REGIONS - 1)) ? '0 : grant_idx + 1'b1;
                    retry_d  = '0;
                    timer_d  = '0;
                    state_d  = StVeto;
                end
            end
            StVeto: begin
                if (timer_q == TW'(VETO_CYCLES - 1)) begin
                    timer_d = '0;
                    state_d = StReq;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StReq: begin
                if (dpr.dpr_ack) begin
                    timer_d = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                timer_d = timer_q + 1'b1;
                // err beats done; a done landing on the last timeout cycle still counts.
                if (dpr.dpr_err || (wait_timeout && !dpr.dpr_done)) begin
                    timer_d = '0;
                    if (retry_q < RTW'(MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = StVeto;
                    end else begin
                        fail_set[region_q] = 1'b1;
                        state_d            = StCool;
                    end
                end else if (dpr.dpr_done) begin
                    timer_d = '0;
                    if (heal_q != {CNT_W{1'b1}}) begin
                        heal_d = heal_q + 1'b1;
                    end
                    state_d = StCool;
                end
            end
            StCool: begin
                if (timer_q == TW'(COOL_CYCLES - 1)) begin
                    timer_d = '0;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_600mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            sefi_q   <= '0;
            pend_q   <= '0;
            failed_q <= '0;
            region_q <= '0;
            ptr_q    <= '0;
            retry_q  <= '0;
            timer_q  <= '0;
            heal_q   <= '0;
        end else begin
            state_q  <= state_d;
            sefi_q   <= sefi_flag;
            pend_q   <= pend_d;
            failed_q <= failed_d;
            region_q <= region_d;
            ptr_q    <= ptr_d;
            retry_q  <= retry_d;
            timer_q  <= timer_d;
            heal_q   <= heal_d;
        end
    end

    assign veto_pulse     = (state_q == StVeto) || (state_q == StReq) || (state_q == StWait);
    assign busy           = (state_q != StIdle);
    assign dpr.dpr_req    = (state_q == StReq);
    assign dpr.dpr_region = region_q;
    assign region_failed  = failed_q;
    assign heal_count     = heal_q;

endmodule
